// File: rtl/key_filter_multi.sv
// Purpose: N-channel push-button filter: 2-flop sync, debounce FSM, press/release/auto-repeat pulses.
// Latency: press/release pulse in the cycle after edge DEB_CYCLES+3 of a stable input; outputs registered.
// Backpressure: none; every channel samples key_in each cycle and pulses are never held or queued.
module key_filter_multi #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 1000000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_en,
  output logic [N_KEYS-1:0] key_state
);

  // Counter widths are clamped to 1 so degenerate parameter choices still elaborate.
  localparam int DEB_W    = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = ($clog2(HOLD_MAX) < 1) ? 1 : $clog2(HOLD_MAX);

  localparam logic              REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } state_t;

  genvar g;
  generate
    for (g = 0; g < N_KEYS; g++) begin : g_ch
      logic              sync1, sync2, p;
      state_t            state, state_nxt;
      logic [DEB_W-1:0]  deb_cnt, deb_nxt;
      logic [HOLD_W-1:0] hold_cnt, hold_nxt;
      logic              first_rep, first_nxt;
      logic              press_nxt, release_nxt, repeat_nxt;
      logic              press_q, release_q, repeat_q, en_q;

      // Two-flop synchroniser preloaded with the released level so reset exit sees no edge.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          sync1 <= REL_LVL;
          sync2 <= REL_LVL;
        end else begin
          sync1 <= key_in[g];
          sync2 <= sync1;
        end
      end

      assign p = (sync2 != REL_LVL);

      // State, counters and registered pulse outputs.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          state     <= IDLE;
          deb_cnt   <= '0;
          hold_cnt  <= '0;
          first_rep <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
          en_q      <= 1'b0;
        end else begin
          state     <= state_nxt;
          deb_cnt   <= deb_nxt;
          hold_cnt  <= hold_nxt;
          first_rep <= first_nxt;
          press_q   <= press_nxt;
          release_q <= release_nxt;
          repeat_q  <= repeat_nxt;
          en_q      <= press_nxt | repeat_nxt;
        end
      end

      // Debounce/repeat next-state logic; hold_cnt is left untouched outside DOWN so a
      // bounced release resumes the repeat schedule where it stopped.
      always_comb begin
        state_nxt   = state;
        deb_nxt     = deb_cnt;
        hold_nxt    = hold_cnt;
        first_nxt   = first_rep;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
          IDLE: begin
            if (p) begin
              state_nxt = FILTER0;
              deb_nxt   = '0;
            end
          end
          FILTER0: begin
            if (!p) begin
              state_nxt = IDLE;
              deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
              state_nxt = DOWN;
              deb_nxt   = '0;
              press_nxt = 1'b1;
              hold_nxt  = '0;
              first_nxt = 1'b1;
            end else begin
              deb_nxt = deb_cnt + DEB_W'(1);
            end
          end
          DOWN: begin
            if (!p) begin
              state_nxt = FILTER1;
              deb_nxt   = '0;
            end else if (REPEAT_EN != 0) begin
              if (hold_cnt == (first_rep ? HOLD_LAST : REP_LAST)) begin
                repeat_nxt = 1'b1;
                hold_nxt   = '0;
                first_nxt  = 1'b0;
              end else begin
                hold_nxt = hold_cnt + HOLD_W'(1);
              end
            end
          end
          FILTER1: begin
            if (p) begin
              state_nxt = DOWN;
              deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
              state_nxt   = IDLE;
              deb_nxt     = '0;
              hold_nxt    = '0;
              first_nxt   = 1'b0;
              release_nxt = 1'b1;
            end else begin
              deb_nxt = deb_cnt + DEB_W'(1);
            end
          end
          default: begin
            state_nxt = IDLE;
            deb_nxt   = '0;
            hold_nxt  = '0;
            first_nxt = 1'b0;
          end
        endcase
      end

      assign key_press[g]   = press_q;
      assign key_release[g] = release_q;
      assign key_repeat[g]  = repeat_q;
      assign key_en[g]      = en_q;
      assign key_state[g]   = (state == DOWN) || (state == FILTER1);
    end
  endgenerate

endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
- Parametrised successor to the single-key debouncer: N independent key channels, each with its own synchroniser, debounce FSM and counters.
- Emits one-cycle press and release pulses and a debounced level per channel.
- Adds optional hold-to-auto-repeat, so game control logic (snake direction, menu) receives repeated key_en strobes while a key is held.
- Sits between the board push-buttons and the game controller.

Parameters:
N_KEYS, 4, number of independent key channels
DEB_CYCLES, 1000000, debounce window in Clk cycles (20 ms at 50 MHz); must be >= 2
ACTIVE_LOW, 1, 1: a pressed key reads 0 on key_in; 0: a pressed key reads 1
REPEAT_EN, 1, 1 enables auto-repeat; 0 means key_repeat is never asserted
HOLD_CYCLES, 25000000, cycles held in DOWN before the first repeat pulse (500 ms); must be >= 1
REPEAT_CYCLES, 5000000, cycles between later repeat pulses (100 ms); must be >= 1

Ports:
Clk  input  1  system clock, 50 MHz
Rst  input  1  asynchronous active-high reset
key_in  input  N_KEYS  raw asynchronous key inputs
key_press  output  N_KEYS  one-cycle pulse per channel when a press is confirmed
key_release  output  N_KEYS  one-cycle pulse per channel when a release is confirmed
key_repeat  output  N_KEYS  one-cycle auto-repeat pulse per channel
key_en  output  N_KEYS  per channel, key_press OR key_repeat, registered
key_state  output  N_KEYS  debounced level per channel, 1 = pressed

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (Clk, Rst).
- Reset values: all outputs 0; every FSM in IDLE; all counters 0; synchroniser flops loaded with the released level (1 if ACTIVE_LOW, else 0), so leaving reset never produces a false edge.
- Rst asserted mid-operation clears everything immediately, including a pending pulse. A key held through reset release must first pass the full debounce window before key_press fires.
- Channel independence: channels share nothing except Clk and Rst. Simultaneous events on different channels produce pulses in the same cycle.
- Synchroniser: 2 flops per channel. Internal level p = 1 when the synchronised input is at the pressed level.
- Per-channel FSM, states IDLE, FILTER0, DOWN, FILTER1:
  - IDLE: if p, go to FILTER0 with deb_cnt = 0.
  - FILTER0:
    - If !p, go to IDLE; no pulse.
    - Else if deb_cnt == DEB_CYCLES-1, go to DOWN: key_press = 1 for one cycle, key_state = 1, hold_cnt = 0, first_rep = 1.
    - Otherwise deb_cnt++.
  - DOWN:
    - If !p, go to FILTER1 with deb_cnt = 0; hold_cnt is frozen.
    - Else hold_cnt++. When REPEAT_EN and hold_cnt == (first_rep ? HOLD_CYCLES-1 : REPEAT_CYCLES-1): key_repeat = 1 for one cycle, hold_cnt = 0, first_rep = 0.
  - FILTER1:
    - If p, go back to DOWN; deb_cnt cleared; hold_cnt and first_rep keep their frozen values.
    - Else if deb_cnt == DEB_CYCLES-1, go to IDLE: key_release = 1 for one cycle, key_state = 0.
    - Otherwise deb_cnt++.
  - Any illegal state encoding returns to IDLE with counters cleared.
- Latency: with key_in stable from just before edge 1, key_press is high in the cycle after rising edge DEB_CYCLES+3. The same holds for key_release. key_en follows key_press and key_repeat in the same cycle, as a registered OR.
- Counter widths: deb_cnt is $clog2(DEB_CYCLES) bits. hold_cnt is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)) bits. Counters never wrap: each is cleared at its terminal value.
- Bounce: any return to the opposite level inside a filter window aborts that window with no pulse. key_press and key_release always alternate per channel.
- Repeat timing: the first repeat fires HOLD_CYCLES cycles after key_press; later repeats fire every REPEAT_CYCLES cycles. Release debounce time is excluded from this timing.

Test Plan (small parameters: DEB_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, N_KEYS=4, ACTIVE_LOW=1):
1. Reset: hold Rst high for 3 cycles with key_in=4'b1111, then release and idle for 50 cycles -> all outputs stay 0.
2. Clean press on key0:
   - Drive key_in[0]=0 and hold -> key_press[0] and key_en[0] pulse for exactly 1 cycle after edge 11; key_state[0]=1 from then on.
   - Release (key_in[0]=1) -> key_release[0] pulses after edge 11 relative to the release; key_state[0]=0.
3. Bounce: key_in[0] toggles low/high every 3 cycles for 40 cycles, then stays high -> no key_press, key_release or key_state activity.
4. Auto-repeat: hold key1 for 60 cycles after key_press[1] -> key_repeat[1] pulses at 20, 25, 30, … 60 cycles after key_press[1], i.e. 9 pulses; key_en[1] mirrors them; no key_release during the hold.
5. Release glitch: in DOWN, a 4-cycle high glitch on key2 -> no key_release[2]; key_state[2] stays 1; the repeat schedule resumes from the frozen hold_cnt.
6. Simultaneous keys and reset:
   - Press key0 and key3 in the same cycle -> both key_press bits pulse in the same cycle.
   - Assert Rst during key3 FILTER1 -> all outputs 0 at once; no key_release[3] after reset is deasserted.
